// File: rtl/prog_loader.sv
// Boot-time program loader: holds the CPU in reset, streams instruction words into
// consecutive memory addresses, then hands the memory back and releases the CPU.
module prog_loader #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 MAX_WORDS = 256,
  parameter int                 HOLD_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              bench_sel,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_ERR
  } state_t;

  state_t              r_state, w_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]    r_acc_cnt;
  logic [ADDR_W-1:0]   r_word_count;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic                w_at_limit, w_accept, w_start, w_hold_done;
  logic                w_load_ready, w_cpu_rst, w_bench_sel, w_done, w_error;

  // Limit tracks accepted beats, not completed writes, so the write pipeline
  // cannot let beat MAX_WORDS+1 slip through.
  assign w_at_limit  = (r_acc_cnt == CNT_W'(MAX_WORDS));
  assign w_accept    = load_valid && w_load_ready;
  assign w_start     = load_start && (r_state inside {S_IDLE, S_RUN, S_ERR});
  assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_CYC - 1));

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next       = r_state;
    w_load_ready = 1'b0;
    w_cpu_rst    = 1'b1;
    w_bench_sel  = 1'b1;
    w_done       = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      S_IDLE:  if (load_start) w_next = S_HOLD;
      S_HOLD:  if (w_hold_done) w_next = S_LOAD;
      S_LOAD: begin
        w_load_ready = !w_at_limit;
        if (load_valid && !w_at_limit && load_last) w_next = S_DRAIN;
        else if (load_valid && w_at_limit)          w_next = S_ERR;
      end
      S_DRAIN: w_next = S_RUN;
      S_RUN: begin
        w_cpu_rst   = 1'b0;
        w_bench_sel = 1'b0;
        w_done      = 1'b1;
        if (load_start) w_next = S_HOLD;
      end
      S_ERR: begin
        w_error = 1'b1;
        if (load_start) w_next = S_HOLD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_acc_cnt    <= '0;
      r_word_count <= '0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= BASE_ADDR + ADDR_W'(r_acc_cnt);
        r_mem_wdata <= load_data;
        r_acc_cnt   <= r_acc_cnt + CNT_W'(1);
      end
      if (w_start) begin
        r_word_count <= '0;
        r_acc_cnt    <= '0;
        r_hold_cnt   <= '0;
      end else begin
        if (r_mem_we)          r_word_count <= r_word_count + ADDR_W'(1);
        if (r_state == S_HOLD) r_hold_cnt   <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign load_ready = w_load_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign bench_sel  = w_bench_sel;
  assign cpu_rst    = w_cpu_rst;
  assign done       = w_done;
  assign error      = w_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: default, small-limit and offset-base instances
// share one clock; each instance has a write monitor popping expected writes.
module tb_prog_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wr_t qa[$];
  wr_t qb[$];
  wr_t qc[$];
  wr_t ea, eb, ec;
  logic [15:0] prog [20];

  // Instance a: default parameters
  logic a_load_start = 0, a_load_valid = 0, a_load_last = 0;
  logic [15:0] a_load_data = '0;
  logic a_load_ready, a_mem_we, a_bench_sel, a_cpu_rst, a_done, a_error;
  logic [15:0] a_mem_addr, a_mem_wdata, a_word_count;

  prog_loader dut_a (
    .clk(clk), .reset(reset), .load_start(a_load_start), .load_valid(a_load_valid),
    .load_ready(a_load_ready), .load_data(a_load_data), .load_last(a_load_last),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .bench_sel(a_bench_sel), .cpu_rst(a_cpu_rst), .done(a_done), .error(a_error),
    .word_count(a_word_count)
  );

  // Instance b: MAX_WORDS=4
  logic b_load_start = 0, b_load_valid = 0, b_load_last = 0;
  logic [15:0] b_load_data = '0;
  logic b_load_ready, b_mem_we, b_bench_sel, b_cpu_rst, b_done, b_error;
  logic [15:0] b_mem_addr, b_mem_wdata, b_word_count;

  prog_loader #(.MAX_WORDS(4), .HOLD_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .load_start(b_load_start), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .load_data(b_load_data), .load_last(b_load_last),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .bench_sel(b_bench_sel), .cpu_rst(b_cpu_rst), .done(b_done), .error(b_error),
    .word_count(b_word_count)
  );

  // Instance c: BASE_ADDR=16'h0010
  logic c_load_start = 0, c_load_valid = 0, c_load_last = 0;
  logic [15:0] c_load_data = '0;
  logic c_load_ready, c_mem_we, c_bench_sel, c_cpu_rst, c_done, c_error;
  logic [15:0] c_mem_addr, c_mem_wdata, c_word_count;

  prog_loader #(.BASE_ADDR(16'h0010), .HOLD_CYC(2)) dut_c (
    .clk(clk), .reset(reset), .load_start(c_load_start), .load_valid(c_load_valid),
    .load_ready(c_load_ready), .load_data(c_load_data), .load_last(c_load_last),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_we(c_mem_we),
    .bench_sel(c_bench_sel), .cpu_rst(c_cpu_rst), .done(c_done), .error(c_error),
    .word_count(c_word_count)
  );

  // Write monitors: every mem_we cycle must match the oldest expected write
  always @(negedge clk) begin
    if (a_mem_we !== 1'b0) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_write: unexpected write addr=%h data=%h, required none", a_mem_addr, a_mem_wdata);
      end else begin
        ea = qa.pop_front();
        if ({a_mem_addr, a_mem_wdata} !== {ea.addr, ea.data}) begin
          errors++;
          $display("FAIL a_write: got addr=%h data=%h, required addr=%h data=%h",
                   a_mem_addr, a_mem_wdata, ea.addr, ea.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_mem_we !== 1'b0) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_write: unexpected write addr=%h data=%h, required none", b_mem_addr, b_mem_wdata);
      end else begin
        eb = qb.pop_front();
        if ({b_mem_addr, b_mem_wdata} !== {eb.addr, eb.data}) begin
          errors++;
          $display("FAIL b_write: got addr=%h data=%h, required addr=%h data=%h",
                   b_mem_addr, b_mem_wdata, eb.addr, eb.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_mem_we !== 1'b0) begin
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL c_write: unexpected write addr=%h data=%h, required none", c_mem_addr, c_mem_wdata);
      end else begin
        ec = qc.pop_front();
        if ({c_mem_addr, c_mem_wdata} !== {ec.addr, ec.data}) begin
          errors++;
          $display("FAIL c_write: got addr=%h data=%h, required addr=%h data=%h",
                   c_mem_addr, c_mem_wdata, ec.addr, ec.data);
        end
      end
    end
  end

  task automatic pulse_start_a();
    a_load_start = 1'b1;
    @(posedge clk); #1;
    a_load_start = 1'b0;
  endtask

  // Presents one beat and waits (bounded) for acceptance; expectation pushed on accept
  task automatic send_a(input logic [15:0] d, input logic last, input logic [15:0] addr);
    int waited = 0;
    a_load_valid = 1'b1;
    a_load_data  = d;
    a_load_last  = last;
    @(negedge clk);
    while (a_load_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (a_load_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_a_timeout: load_ready=%b, required 1", a_load_ready);
    end else begin
      qa.push_back('{addr: addr, data: d});
    end
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    a_load_last  = 1'b0;
  endtask

  task automatic load_a(input int n, input bit with_last, input bit gapped, input bit inv);
    for (int i = 0; i < n; i++) begin
      send_a(inv ? ~prog[i] : prog[i], with_last && (i == n - 1), 16'(i));
      if (gapped && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_b(input logic [15:0] d, input logic [15:0] addr);
    int waited = 0;
    b_load_valid = 1'b1;
    b_load_data  = d;
    @(negedge clk);
    while (b_load_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (b_load_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_b_timeout: load_ready=%b, required 1", b_load_ready);
    end else begin
      qb.push_back('{addr: addr, data: d});
    end
    @(posedge clk); #1;
    b_load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_cpu_rst, a_bench_sel, a_mem_we, a_load_ready, a_done, a_error} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 110000",
               {a_cpu_rst, a_bench_sel, a_mem_we, a_load_ready, a_done, a_error});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_word_count} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h count=%h, required all 0",
               a_mem_addr, a_mem_wdata, a_word_count);
    end
    checks++;
    if (c_mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL reset_base: c mem_addr=%h, required 0010", c_mem_addr);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // T1: 20 words back-to-back, handoff exactly 2 cycles after the last accept
  task automatic test_stream();
    pulse_start_a();
    load_a(20, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({a_cpu_rst, a_bench_sel, a_done} !== 3'b110) begin
      errors++;
      $display("FAIL stream_drain: cpu_rst,bench_sel,done=%b, required 110", {a_cpu_rst, a_bench_sel, a_done});
    end
    @(negedge clk);
    checks++;
    if ({a_cpu_rst, a_bench_sel, a_done, a_error} !== 4'b0010) begin
      errors++;
      $display("FAIL stream_run: cpu_rst,bench_sel,done,error=%b, required 0010",
               {a_cpu_rst, a_bench_sel, a_done, a_error});
    end
    checks++;
    if (a_word_count !== 16'd20) begin
      errors++;
      $display("FAIL stream_count: word_count=%0d, required 20", a_word_count);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL stream_drained: %0d writes missing, required 0", qa.size());
    end
    @(posedge clk); #1;
  endtask

  // T2: valid toggles 1/0; same image expected, no writes on gap cycles
  task automatic test_gapped();
    pulse_start_a();
    load_a(20, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({a_done, a_cpu_rst, a_word_count} !== {1'b1, 1'b0, 16'd20}) begin
      errors++;
      $display("FAIL gapped_run: done=%b cpu_rst=%b count=%0d, required 1 0 20", a_done, a_cpu_rst, a_word_count);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL gapped_drained: %0d writes missing, required 0", qa.size());
    end
    @(posedge clk); #1;
  endtask

  // T6: restart from RUN; HOLD blocks beats for HOLD_CYC cycles
  task automatic test_restart();
    int held = 0;
    pulse_start_a();
    a_load_valid = 1'b1;
    a_load_data  = ~prog[0];
    @(negedge clk);
    checks++;
    if ({a_cpu_rst, a_bench_sel, a_done, a_word_count} !== {3'b110, 16'd0}) begin
      errors++;
      $display("FAIL restart_next: cpu_rst,bench_sel,done=%b count=%0d, required 110 0",
               {a_cpu_rst, a_bench_sel, a_done}, a_word_count);
    end
    while (a_load_ready !== 1'b1 && held < 40) begin
      held++;
      @(negedge clk);
    end
    checks++;
    if (held != 10) begin
      errors++;
      $display("FAIL restart_hold: load_ready low for %0d cycles, required 10", held);
    end
    a_load_valid = 1'b0;
    @(posedge clk); #1;
    load_a(20, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({a_done, a_cpu_rst, a_bench_sel, a_word_count} !== {3'b100, 16'd20}) begin
      errors++;
      $display("FAIL restart_run: done,cpu_rst,bench_sel=%b count=%0d, required 100 20",
               {a_done, a_cpu_rst, a_bench_sel}, a_word_count);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL restart_drained: %0d writes missing, required 0", qa.size());
    end
    @(posedge clk); #1;
  endtask

  // T5: async reset after 5 words, then a full reload from BASE_ADDR
  task automatic test_reset_midload();
    pulse_start_a();
    load_a(5, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({a_cpu_rst, a_bench_sel, a_mem_we, a_load_ready, a_done, a_error,
         a_mem_addr, a_mem_wdata, a_word_count} !== {6'b110000, 48'h0}) begin
      errors++;
      $display("FAIL midload_reset: ctrl=%b addr=%h wdata=%h count=%h, required 110000 0 0 0",
               {a_cpu_rst, a_bench_sel, a_mem_we, a_load_ready, a_done, a_error},
               a_mem_addr, a_mem_wdata, a_word_count);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL midload_partial: %0d writes missing, required 0", qa.size());
    end
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    pulse_start_a();
    load_a(20, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({a_done, a_word_count, qa.size()} !== {1'b1, 16'd20, 32'd0}) begin
      errors++;
      $display("FAIL midload_reload: done=%b count=%0d pending=%0d, required 1 20 0",
               a_done, a_word_count, qa.size());
    end
    @(posedge clk); #1;
  endtask

  // T3: MAX_WORDS=4, six beats without last
  task automatic test_overflow();
    b_load_start = 1'b1;
    @(posedge clk); #1;
    b_load_start = 1'b0;
    for (int i = 0; i < 4; i++) send_b(16'hA000 + 16'(i), 16'(i));
    b_load_valid = 1'b1;
    b_load_data  = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (b_load_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_ready: load_ready=%b at limit, required 0", b_load_ready);
    end
    @(posedge clk); #1;
    b_load_data = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({b_error, b_cpu_rst, b_bench_sel, b_load_ready, b_done} !== 5'b11100) begin
      errors++;
      $display("FAIL overflow_err: error,cpu_rst,bench_sel,ready,done=%b, required 11100",
               {b_error, b_cpu_rst, b_bench_sel, b_load_ready, b_done});
    end
    checks++;
    if (b_word_count !== 16'd4) begin
      errors++;
      $display("FAIL overflow_count: word_count=%0d, required 4", b_word_count);
    end
    repeat (2) @(negedge clk);
    b_load_valid = 1'b0;
    checks++;
    if ({b_error, b_cpu_rst, qb.size()} !== {2'b11, 32'd0}) begin
      errors++;
      $display("FAIL overflow_hold: error=%b cpu_rst=%b pending=%0d, required 1 1 0",
               b_error, b_cpu_rst, qb.size());
    end
    @(posedge clk); #1;
  endtask

  // T4: BASE_ADDR=0x0010, one-word program with last on the first beat
  task automatic test_base_single();
    int waited = 0;
    c_load_start = 1'b1;
    @(posedge clk); #1;
    c_load_start = 1'b0;
    c_load_valid = 1'b1;
    c_load_data  = 16'h1234;
    c_load_last  = 1'b1;
    @(negedge clk);
    while (c_load_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (c_load_ready !== 1'b1) begin
      errors++;
      $display("FAIL base_timeout: load_ready=%b, required 1", c_load_ready);
    end else begin
      qc.push_back('{addr: 16'h0010, data: 16'h1234});
    end
    @(posedge clk); #1;
    c_load_valid = 1'b0;
    c_load_last  = 1'b0;
    @(negedge clk);
    checks++;
    if (c_done !== 1'b0) begin
      errors++;
      $display("FAIL base_drain: done=%b one cycle after accept, required 0", c_done);
    end
    @(negedge clk);
    checks++;
    if ({c_done, c_cpu_rst, c_bench_sel, c_word_count, qc.size()} !== {3'b100, 16'd1, 32'd0}) begin
      errors++;
      $display("FAIL base_run: done,cpu_rst,bench_sel=%b count=%0d pending=%0d, required 100 1 0",
               {c_done, c_cpu_rst, c_bench_sel}, c_word_count, qc.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) prog[i] = 16'h2000 + 16'(i * 16'h0101);
    prog[0]  = 16'hB010;
    prog[1]  = 16'hEA00;
    prog[18] = 16'h4FF3;
    prog[19] = 16'h0FFF;
    test_reset();
    test_stream();
    test_gapped();
    test_restart();
    test_reset_midload();
    test_overflow();
    test_base_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
